vdp_pixel_mixer: RTL and testbench

Final pixel stage of the VDP, downstream of the background and sprite generators. Each cycle it takes one background pixel and one sprite pixel from `vdp_sprites`, resolves priority and transparency, and looks the winning entry up in colour RAM (CRAM). It also applies left-column masking, display enable and the active-window gate, and produces registered 12-bit RGB plus a data-enable. It owns the CRAM write port, including Game Gear two-byte latching, and the sticky sprite-collision status flag.

---
 rtl/vdp_pixel_mixer_if.sv | 35 +++
 rtl/vdp_pixel_mixer.sv | 112 +++++++++++
 tb/tb_vdp_pixel_mixer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_pixel_mixer_if.sv
// rtl/vdp_pixel_mixer_if.sv - pixel, CRAM write and RGB output bundle of the VDP pixel mixer
interface vdp_pixel_mixer_if;
   logic [8:0] pixel_x;
   logic [8:0] pixel_y;
   logic [4:0] bg_color;
   logic       bg_priority;
   logic [5:0] spr_color;
   logic [3:0] backdrop;
   logic       mask_col0;
   logic       display_en;
   logic       cram_we;
   logic [5:0] cram_addr;
   logic [7:0] cram_wdata;
   logic       spr_collide;
   logic       status_clr;
   logic [3:0] red;
   logic [3:0] green;
   logic [3:0] blue;
   logic       de;
   logic       collision;

   modport master (
      output pixel_x, pixel_y, bg_color, bg_priority, spr_color, backdrop,
      output mask_col0, display_en, cram_we, cram_addr, cram_wdata,
      output spr_collide, status_clr,
      input  red, green, blue, de, collision
   );

   modport slave (
      input  pixel_x, pixel_y, bg_color, bg_priority, spr_color, backdrop,
      input  mask_col0, display_en, cram_we, cram_addr, cram_wdata,
      input  spr_collide, status_clr,
      output red, green, blue, de, collision
   );
endinterface

// File: rtl/vdp_pixel_mixer.sv
// rtl/vdp_pixel_mixer.sv - VDP final pixel stage: priority, CRAM lookup, window gate, RGB out
module vdp_pixel_mixer #(
   parameter logic GG_MODE = 1'b1
) (
   input logic              clk,
   input logic              rst,
   vdp_pixel_mixer_if.slave bus
);
   logic [11:0] cram [32];
   logic [7:0]  gg_latch;
   logic [11:0] cram_rd;

   logic       in_window;
   logic [4:0] sel_idx;

   logic       s1_win;
   logic       s1_black;
   logic [4:0] s1_idx;

   logic [3:0] red_q;
   logic [3:0] green_q;
   logic [3:0] blue_q;
   logic       de_q;
   logic       collision_q;

   logic unused_inputs;
   assign unused_inputs = ^{bus.spr_color[0], bus.cram_addr[5], bus.cram_wdata[7:6]};

   always_comb begin
      if (GG_MODE)
         in_window = (bus.pixel_x >= 9'd48) && (bus.pixel_x <= 9'd207) &&
                     (bus.pixel_y >= 9'd24) && (bus.pixel_y <= 9'd167);
      else
         in_window = !bus.pixel_x[8] && (bus.pixel_y < 9'd192);
   end

   // An opaque high-priority background pixel must beat the sprite, hence the explicit middle arm.
   always_comb begin
      sel_idx = bus.bg_color;
      if (bus.mask_col0 && (bus.pixel_x < 9'd8))
         sel_idx = {1'b1, bus.backdrop};
      else if (bus.bg_priority && (bus.bg_color[3:0] != 4'd0))
         sel_idx = bus.bg_color;
      else if (bus.spr_color[5] && (bus.spr_color[4:1] != 4'd0))
         sel_idx = {1'b1, bus.spr_color[4:1]};
   end

   // Game Gear colours arrive as a byte pair; the even byte waits in gg_latch until the odd one commits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gg_latch <= '0;
         for (int i = 0; i < 32; i++)
            cram[i] <= '0;
      end else if (bus.cram_we) begin
         if (GG_MODE) begin
            if (!bus.cram_addr[0])
               gg_latch <= bus.cram_wdata;
            else
               cram[bus.cram_addr[5:1]] <= {bus.cram_wdata[3:0], gg_latch};
         end else begin
            cram[bus.cram_addr[4:0]] <= {{2{bus.cram_wdata[5:4]}},
                                         {2{bus.cram_wdata[3:2]}},
                                         {2{bus.cram_wdata[1:0]}}};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_win   <= 1'b0;
         s1_black <= 1'b0;
         s1_idx   <= '0;
      end else begin
         s1_win   <= in_window;
         s1_black <= !bus.display_en;
         s1_idx   <= sel_idx;
      end
   end

   // Read-first: a commit on the same edge lands after this lookup has sampled the old entry.
   assign cram_rd = cram[s1_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         de_q    <= 1'b0;
      end else begin
         de_q <= s1_win;
         if (s1_win && !s1_black)
            {blue_q, green_q, red_q} <= cram_rd;
         else
            {blue_q, green_q, red_q} <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         collision_q <= 1'b0;
      else if (bus.spr_collide)
         collision_q <= 1'b1;
      else if (bus.status_clr)
         collision_q <= 1'b0;
   end

   assign bus.red       = red_q;
   assign bus.green     = green_q;
   assign bus.blue      = blue_q;
   assign bus.de        = de_q;
   assign bus.collision = collision_q;
endmodule

// File: tb/tb_vdp_pixel_mixer.sv
// tb/tb_vdp_pixel_mixer.sv - self-checking bench for vdp_pixel_mixer in Game Gear and SMS modes
module tb_vdp_pixel_mixer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [8:0] px, py;
   logic [4:0] bgc;
   logic       bgp;
   logic [5:0] spc;
   logic [3:0] bkd;
   logic       mask, den, we, coll, sclr;
   logic [5:0] addr;
   logic [7:0] wdata;

   int checks = 0;
   int errors = 0;

   vdp_pixel_mixer_if gif ();
   vdp_pixel_mixer_if sif ();

   assign gif.pixel_x = px;     assign sif.pixel_x = px;
   assign gif.pixel_y = py;     assign sif.pixel_y = py;
   assign gif.bg_color = bgc;   assign sif.bg_color = bgc;
   assign gif.bg_priority = bgp; assign sif.bg_priority = bgp;
   assign gif.spr_color = spc;  assign sif.spr_color = spc;
   assign gif.backdrop = bkd;   assign sif.backdrop = bkd;
   assign gif.mask_col0 = mask; assign sif.mask_col0 = mask;
   assign gif.display_en = den; assign sif.display_en = den;
   assign gif.cram_we = we;     assign sif.cram_we = we;
   assign gif.cram_addr = addr; assign sif.cram_addr = addr;
   assign gif.cram_wdata = wdata; assign sif.cram_wdata = wdata;
   assign gif.spr_collide = coll; assign sif.spr_collide = coll;
   assign gif.status_clr = sclr;  assign sif.status_clr = sclr;

   vdp_pixel_mixer #(.GG_MODE(1'b1)) u_gg  (.clk(clk), .rst(rst), .bus(gif.slave));
   vdp_pixel_mixer #(.GG_MODE(1'b0)) u_sms (.clk(clk), .rst(rst), .bus(sif.slave));

   logic [12:0] gg_px, sms_px;
   assign gg_px  = {gif.red, gif.green, gif.blue, gif.de};
   assign sms_px = {sif.red, sif.green, sif.blue, sif.de};

   // Reference model; index 0 = SMS, 1 = Game Gear. Entries hold {B,G,R}.
   logic [11:0] m_cram [2][32];
   logic [7:0]  m_latch;
   logic        m_coll;
   bit          p_win [2];
   bit          p_blk [2];
   int          p_idx [2];
   logic [12:0] exp_px [2];

   function automatic bit win_of(int mode, int x, int y);
      if (mode == 1)
         return (x >= 48) && (x <= 207) && (y >= 24) && (y <= 167);
      return (x < 256) && (y < 192);
   endfunction

   function automatic int entry_of();
      int bg_idx = int'(bgc) % 16;
      int sp_idx = int'(spc[4:1]);
      if (mask && (px < 8)) return 16 + int'(bkd);
      if (bgp && (bg_idx != 0)) return int'(bgc);
      if (spc[5] && (sp_idx != 0)) return 16 + sp_idx;
      return int'(bgc);
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 32; i++) m_cram[m][i] = 12'd0;
         p_win[m] = 0; p_blk[m] = 0; p_idx[m] = 0; exp_px[m] = 13'd0;
      end
      m_latch = 8'd0;
      m_coll  = 1'b0;
   endtask

   task automatic cycle();
      logic [11:0] e;
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         e = m_cram[m][p_idx[m]];
         if (p_win[m] && !p_blk[m]) exp_px[m] = {e[3:0], e[7:4], e[11:8], 1'b1};
         else exp_px[m] = {12'd0, p_win[m]};
      end
      if (we) begin
         if (addr % 2 == 0) m_latch = wdata;
         else m_cram[1][addr / 2] = {wdata[3:0], m_latch};
         m_cram[0][addr % 32] = 12'((int'(wdata[5:4]) * 5) * 256 +
                                    (int'(wdata[3:2]) * 5) * 16 + int'(wdata[1:0]) * 5);
      end
      if (coll) m_coll = 1'b1;
      else if (sclr) m_coll = 1'b0;
      for (int m = 0; m < 2; m++) begin
         p_win[m] = win_of(m, int'(px), int'(py));
         p_blk[m] = !den;
         p_idx[m] = entry_of();
      end
      #1;
   endtask

   task automatic idle();
      px = 9'd0; py = 9'd300; bgc = 5'd0; bgp = 1'b0; spc = 6'd0; bkd = 4'd0;
      mask = 1'b0; den = 1'b1; we = 1'b0; addr = 6'd0; wdata = 8'd0; coll = 1'b0; sclr = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1; we = 1'b1; addr = 6'h03; wdata = 8'hFF; coll = 1'b1; px = 9'd100; py = 9'd50;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({gg_px, gif.collision} !== 14'd0) begin
         errors++; $display("FAIL reset_gg got %h want 0", {gg_px, gif.collision});
      end
      checks++;
      if ({sms_px, sif.collision} !== 14'd0) begin
         errors++; $display("FAIL reset_sms got %h want 0", {sms_px, sif.collision});
      end
      model_reset();
      idle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_gg_write();
      idle();
      we = 1'b1; addr = 6'h02; wdata = 8'hA5; cycle();
      addr = 6'h03; wdata = 8'h07; cycle();
      we = 1'b0; px = 9'd100; py = 9'd50; bgc = 5'd1;
      cycle(); cycle();
      checks++;
      if (gg_px !== {4'h5, 4'hA, 4'h7, 1'b1}) begin
         errors++; $display("FAIL gg_write got %h want %h", gg_px, {4'h5, 4'hA, 4'h7, 1'b1});
      end
      checks++;
      if (sms_px !== 13'd1) begin
         errors++; $display("FAIL gg_write_sms got %h want %h", sms_px, 13'd1);
      end
      we = 1'b1; addr = 6'h03; wdata = 8'h0C; cycle();
      checks++;
      if (gg_px !== {4'h5, 4'hA, 4'h7, 1'b1}) begin
         errors++; $display("FAIL read_first_old got %h want %h", gg_px, {4'h5, 4'hA, 4'h7, 1'b1});
      end
      we = 1'b0; cycle();
      checks++;
      if (gg_px !== {4'h5, 4'hA, 4'hC, 1'b1}) begin
         errors++; $display("FAIL read_first_new got %h want %h", gg_px, {4'h5, 4'hA, 4'hC, 1'b1});
      end
   endtask

   task automatic test_sms_write();
      idle();
      we = 1'b1; addr = 6'h11; wdata = 8'h1B; cycle();
      we = 1'b0; px = 9'd10; py = 9'd10; bgc = 5'd3; spc = 6'b100010;
      cycle(); cycle();
      checks++;
      if (sms_px !== {4'hF, 4'hA, 4'h5, 1'b1}) begin
         errors++; $display("FAIL sms_write got %h want %h", sms_px, {4'hF, 4'hA, 4'h5, 1'b1});
      end
      checks++;
      if (gg_px !== 13'd0) begin
         errors++; $display("FAIL sms_write_gg_outside got %h want 0", gg_px);
      end
   endtask

   task automatic test_priority();
      logic [4:0]  t_bgc [4] = '{5'd2, 5'd2, 5'd2, 5'd0};
      logic        t_bgp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [5:0]  t_spc [4] = '{6'b100010, 6'b100010, 6'b100001, 6'b100010};
      logic [12:0] t_exp [4] = '{{4'h0, 4'h0, 4'hF, 1'b1}, {4'hF, 4'hA, 4'h5, 1'b1},
                                 {4'h0, 4'h0, 4'hF, 1'b1}, {4'hF, 4'hA, 4'h5, 1'b1}};
      idle();
      we = 1'b1; addr = 6'h02; wdata = 8'h30; cycle();
      we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         px = 9'd10; py = 9'd10; bgc = t_bgc[i]; bgp = t_bgp[i]; spc = t_spc[i];
         cycle(); cycle();
         checks++;
         if (sms_px !== t_exp[i]) begin
            errors++; $display("FAIL priority_%0d got %h want %h", i, sms_px, t_exp[i]);
         end
      end
   endtask

   task automatic test_window_mask();
      int t_x [11] = '{47, 48, 207, 208, 100, 100, 100, 100, 255, 256, 0};
      int t_y [11] = '{50, 50, 50, 50, 23, 24, 167, 168, 191, 0, 192};
      bit t_gg [11] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
      bit t_sm [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
      idle();
      bgc = 5'd1;
      for (int i = 0; i < 11; i++) begin
         px = 9'(t_x[i]); py = 9'(t_y[i]);
         cycle(); cycle();
         checks++;
         if (gif.de !== t_gg[i] || (!t_gg[i] && gg_px !== 13'd0)) begin
            errors++; $display("FAIL window_gg x=%0d y=%0d got %h want de=%0d", t_x[i], t_y[i], gg_px, t_gg[i]);
         end
         checks++;
         if (sif.de !== t_sm[i]) begin
            errors++; $display("FAIL window_sms x=%0d y=%0d got %b want %b", t_x[i], t_y[i], sif.de, t_sm[i]);
         end
      end
      mask = 1'b1; bkd = 4'd1; bgc = 5'd2; bgp = 1'b1; py = 9'd10;
      for (int x = 0; x <= 8; x++) begin
         px = 9'(x);
         cycle(); cycle();
         checks++;
         if (sms_px !== ((x < 8) ? {4'hF, 4'hA, 4'h5, 1'b1} : {4'h0, 4'h0, 4'hF, 1'b1})) begin
            errors++; $display("FAIL mask_x%0d got %h", x, sms_px);
         end
      end
      mask = 1'b0; den = 1'b0; px = 9'd100; py = 9'd50;
      cycle(); cycle();
      checks++;
      if ({gg_px, sms_px} !== {13'd1, 13'd1}) begin
         errors++; $display("FAIL display_off got %h want %h", {gg_px, sms_px}, {13'd1, 13'd1});
      end
   endtask

   task automatic test_collision();
      logic t_c [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic t_s [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic t_e [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      idle();
      coll = 1'b1;
      checks++;
      if ({gif.collision, sif.collision} !== 2'b00) begin
         errors++; $display("FAIL collide_early got %b want 00", {gif.collision, sif.collision});
      end
      for (int i = 0; i < 5; i++) begin
         coll = t_c[i]; sclr = t_s[i];
         cycle();
         checks++;
         if ({gif.collision, sif.collision} !== {2{t_e[i]}}) begin
            errors++; $display("FAIL collision_%0d got %b want %b", i, {gif.collision, sif.collision}, {2{t_e[i]}});
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         px = 9'($urandom_range(0, 300)); py = 9'($urandom_range(0, 200));
         bgc = 5'($urandom); bgp = 1'($urandom); spc = 6'($urandom); bkd = 4'($urandom);
         mask = ($urandom_range(0, 3) == 0); den = ($urandom_range(0, 7) != 0);
         we = ($urandom_range(0, 3) == 0); addr = 6'($urandom); wdata = 8'($urandom);
         coll = ($urandom_range(0, 7) == 0); sclr = ($urandom_range(0, 7) == 0);
         cycle();
         checks++;
         if (gg_px !== exp_px[1] || gif.collision !== m_coll) begin
            errors++; $display("FAIL random_gg n=%0d got %h/%b want %h/%b", n, gg_px, gif.collision, exp_px[1], m_coll);
         end
         checks++;
         if (sms_px !== exp_px[0] || sif.collision !== m_coll) begin
            errors++; $display("FAIL random_sms n=%0d got %h/%b want %h/%b", n, sms_px, sif.collision, exp_px[0], m_coll);
         end
      end
   endtask

   task automatic test_reset_mid_write();
      idle();
      px = 9'd100; py = 9'd50; bgc = 5'd1; coll = 1'b1;
      we = 1'b1; addr = 6'h02; wdata = 8'hA5; cycle();
      we = 1'b0; coll = 1'b0; cycle();
      checks++;
      if ({gif.de, gif.collision} !== 2'b11) begin
         errors++; $display("FAIL pre_reset got %b want 11", {gif.de, gif.collision});
      end
      rst = 1'b1;
      #2;
      checks++;
      if ({gg_px, gif.collision, sms_px, sif.collision} !== 28'd0) begin
         errors++; $display("FAIL async_reset got %h want 0", {gg_px, gif.collision, sms_px, sif.collision});
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      we = 1'b1; addr = 6'h03; wdata = 8'h07; cycle();
      we = 1'b0; cycle(); cycle();
      checks++;
      if (gg_px !== {4'h0, 4'h0, 4'h7, 1'b1}) begin
         errors++; $display("FAIL reset_latch got %h want %h", gg_px, {4'h0, 4'h0, 4'h7, 1'b1});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_gg_write();
      test_sms_write();
      test_priority();
      test_window_mask();
      test_collision();
      test_random();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
